// File: rtl/uart_vga_io_pkg.sv
// Shared constants and state encodings for the UART/VGA terminal front end.
// The baud divider and the 640x480@60 timing numbers live here so every block agrees on them.
package uart_vga_io_pkg;

    localparam int DEFAULT_CLOCK_RATE = 24_000_000;
    localparam int DEFAULT_BAUD_RATE  = 115_200;

    // Truncating divide: clk cycles per UART bit.
    function automatic int baud_div(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

    localparam int DIV = baud_div(DEFAULT_CLOCK_RATE, DEFAULT_BAUD_RATE);

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_vga_io_bit_timer.sv
// Loadable down-counter that pulses tick in the last cycle of a DIV (or DIV/2) period.
// A load in the tick cycle restarts the period back-to-back, so bit cells stay exactly DIV long.
module uart_bit_timer #(
    parameter int DIV = 208
) (
    input  logic clk,
    input  logic reset,
    input  logic load_full,
    input  logic load_half,
    input  logic halt,
    output logic tick
);

    localparam int W = $clog2(DIV + 1);

    logic [W-1:0] cnt_reg;
    logic         run_reg;

    assign tick = run_reg && (cnt_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (halt) begin
            run_reg <= 1'b0;
        end else if (load_full) begin
            cnt_reg <= W'(DIV - 1);
            run_reg <= 1'b1;
        end else if (load_half) begin
            cnt_reg <= W'(DIV / 2 - 1);
            run_reg <= 1'b1;
        end else if (run_reg) begin
            if (cnt_reg == '0) begin
                run_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_vga_io.sv
// Terminal/video I/O front end: 8N1 UART TX, 8N1 UART RX with valid/ready, 640x480 VGA timing.
// Everything runs on clk, which is also the VGA pixel clock.
module uart_vga_io
    import uart_vga_io_pkg::*;
#(
    parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       tx_ready,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       rx_overrun,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int BIT_DIV = baud_div(CLOCK_RATE, BAUD_RATE);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // ---------------------------------------------------------------- TX
    tx_state_t  tx_state_reg, tx_state_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic       tx_load;
    logic       tx_tick;

    uart_bit_timer #(.DIV(BIT_DIV)) u_tx_timer (
        .clk       (clk),
        .reset     (reset),
        .load_full (tx_load),
        .load_half (1'b0),
        .halt      (1'b0),
        .tick      (tx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
        end
    end

    // tx_enable only gates acceptance; a frame in flight always completes.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_valid && tx_ready) begin
                    tx_state_next = TX_START;
                    tx_shift_next = tx_data;
                    tx_load       = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_next = TX_DATA;
                    tx_bit_next   = '0;
                    tx_load       = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_load       = 1'b1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next = tx_bit_reg + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx_ready = (tx_state_reg == TX_IDLE) && tx_enable;
    assign tx_out   = (tx_state_reg == TX_START) ? 1'b0 :
                      (tx_state_reg == TX_DATA)  ? tx_shift_reg[0] : 1'b1;

    // ---------------------------------------------------------------- RX
    rx_state_t  rx_state_reg, rx_state_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [1:0] rx_sync_reg;
    logic       rx_line;
    logic       rx_load_full, rx_load_half, rx_tick, rx_done;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg, rx_error_reg, rx_overrun_reg;

    uart_bit_timer #(.DIV(BIT_DIV)) u_rx_timer (
        .clk       (clk),
        .reset     (reset),
        .load_full (rx_load_full),
        .load_half (rx_load_half),
        .halt      (!rx_enable),
        .tick      (rx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_reg <= 2'b11;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], rx_in};
        end
    end

    assign rx_line = rx_sync_reg[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_reg <= RX_IDLE;
            rx_shift_reg <= '0;
            rx_bit_reg   <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_shift_reg <= rx_shift_next;
            rx_bit_reg   <= rx_bit_next;
        end
    end

    // The half-bit wait after the falling edge centres every later sample in its bit cell.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_shift_next = rx_shift_reg;
        rx_bit_next   = rx_bit_reg;
        rx_load_full  = 1'b0;
        rx_load_half  = 1'b0;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_line) begin
                    rx_state_next = RX_START_CHK;
                    rx_load_half  = 1'b1;
                end
            end
            RX_START_CHK: begin
                if (rx_tick) begin
                    if (rx_line) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_state_next = RX_DATA;
                        rx_bit_next   = '0;
                        rx_load_full  = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_line, rx_shift_reg[7:1]};
                    rx_load_full  = 1'b1;
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_done       = 1'b1;
                    rx_state_next = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_line) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
        if (!rx_enable) begin
            rx_state_next = RX_IDLE;
            rx_load_full  = 1'b0;
            rx_load_half  = 1'b0;
            rx_done       = 1'b0;
        end
    end

    // Completion is applied after the handshake clear so a same-edge byte survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_error_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            if (rx_valid_reg && rx_ready) begin
                rx_valid_reg   <= 1'b0;
                rx_error_reg   <= 1'b0;
                rx_overrun_reg <= 1'b0;
            end
            if (rx_done) begin
                if (rx_line) begin
                    if (!rx_valid_reg || rx_ready) begin
                        rx_data_reg  <= rx_shift_reg;
                        rx_valid_reg <= 1'b1;
                    end else begin
                        rx_overrun_reg <= 1'b1;
                    end
                end else begin
                    rx_error_reg <= 1'b1;
                end
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign rx_error   = rx_error_reg;
    assign rx_overrun = rx_overrun_reg;

    // ---------------------------------------------------------------- VGA
    logic [9:0] hpos_reg, vpos_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_reg <= '0;
            vpos_reg <= '0;
        end else if (hpos_reg == H_LAST) begin
            hpos_reg <= '0;
            vpos_reg <= (vpos_reg == V_LAST) ? 10'd0 : vpos_reg + 10'd1;
        end else begin
            hpos_reg <= hpos_reg + 10'd1;
        end
    end

    assign hpos       = hpos_reg;
    assign vpos       = vpos_reg;
    assign hsync      = !((hpos_reg >= HS_FIRST) && (hpos_reg <= HS_LAST));
    assign vsync      = !((vpos_reg >= VS_FIRST) && (vpos_reg <= VS_LAST));
    assign display_on = (hpos_reg < H_VIS) && (vpos_reg < V_VIS);

endmodule

// File: tb/tb_uart_vga_io.sv
// Scoreboard bench for uart_vga_io: serial-line TX decoder, RX event scoreboard, VGA timing model.
module tb_uart_vga_io;

    localparam int DIV = 24_000_000 / 115_200;
    localparam int EV_VALID   = 0;
    localparam int EV_ERROR   = 1;
    localparam int EV_OVERRUN = 2;
    localparam int EV_CLEAR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } rx_ev_t;

    logic       clk, reset;
    logic       tx_enable, tx_valid, tx_out, tx_ready;
    logic [7:0] tx_data;
    logic       rx_enable, rx_in, rx_ready, rx_valid, rx_error, rx_overrun;
    logic [7:0] rx_data;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_exp_q[$];
    rx_ev_t     rx_ev_q[$];

    // behavioural RX model: what the receiver's flags should currently be
    logic       m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;

    int vga_t;

    uart_vga_io dut (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_out     (tx_out),
        .tx_ready   (tx_ready),
        .rx_enable  (rx_enable),
        .rx_in      (rx_in),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_overrun (rx_overrun),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- TX line decoder
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx - 1];
    endfunction

    task automatic tx_capture_frame();
        logic       s [0:10*DIV-1];
        bit         aborted;
        int         errs;
        logic [7:0] got_b, exp_b;
        aborted = 0;
        s[0] = tx_out;
        for (int k = 1; k < 10*DIV; k++) begin
            @(negedge clk);
            if (reset) begin
                aborted = 1;
                break;
            end
            s[k] = tx_out;
        end
        if (aborted) return;
        for (int i = 0; i < 8; i++) got_b[i] = s[(i + 1)*DIV + DIV/2];
        if (tx_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_frame: got byte 0x%02h, no byte was sent", got_b);
            return;
        end
        exp_b = tx_exp_q.pop_front();
        errs = 0;
        for (int k = 0; k < 10*DIV; k++) begin
            if (s[k] !== frame_bit(exp_b, k / DIV)) errs++;
        end
        $display("tx frame: got 0x%02h expected 0x%02h, %0d wrong cycles", got_b, exp_b, errs);
        check("tx_frame_cycle_errors", errs, 0);
        check("tx_frame_byte", got_b, exp_b);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tx_out === 1'b0) tx_capture_frame();
        end
    end

    // ---------------------------------------------------------------- RX event monitor
    task automatic rx_expect(input int kind);
        rx_ev_t e;
        if (rx_ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_event: got event kind %0d, none expected (t=%0t)", kind, $time);
            return;
        end
        e = rx_ev_q.pop_front();
        $display("rx event: kind %0d (expected %0d) rx_data=0x%02h expected 0x%02h", kind, e.kind, rx_data, e.data);
        check("rx_event_kind", kind, e.kind);
        if (kind == EV_CLEAR) check("rx_clear_flags", {rx_valid, rx_error, rx_overrun}, 3'b000);
        else                  check("rx_event_data", rx_data, e.data);
    endtask

    initial begin
        logic pv, pe, po;
        pv = 1'b0; pe = 1'b0; po = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0; pe = 1'b0; po = 1'b0;
            end else begin
                if (pv && !rx_valid)   rx_expect(EV_CLEAR);
                if (!pv && rx_valid)   rx_expect(EV_VALID);
                if (!pe && rx_error)   rx_expect(EV_ERROR);
                if (!po && rx_overrun) rx_expect(EV_OVERRUN);
                pv = rx_valid; pe = rx_error; po = rx_overrun;
            end
        end
    end

    // ---------------------------------------------------------------- VGA reference
    always @(posedge clk or posedge reset) begin
        if (reset) vga_t <= 0;
        else       vga_t <= vga_t + 1;
    end

    initial begin
        int   line_err, h, v;
        logic e_hs, e_vs, e_de;
        line_err = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                h    = vga_t % 800;
                v    = (vga_t / 800) % 525;
                e_hs = !(h >= 656 && h <= 751);
                e_vs = !(v >= 490 && v <= 491);
                e_de = (h < 640) && (v < 480);
                if (hpos !== h[9:0] || vpos !== v[9:0] || hsync !== e_hs || vsync !== e_vs || display_on !== e_de) begin
                    if (line_err == 0)
                        $display("vga detail: hpos=%0d vpos=%0d hs=%b vs=%b de=%b, want %0d %0d %b %b %b",
                                 hpos, vpos, hsync, vsync, display_on, h, v, e_hs, e_vs, e_de);
                    line_err++;
                end
                if (h == 799) begin
                    check("vga_line_errors", line_err, 0);
                    line_err = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic send_tx(input logic [7:0] b, input bit toggle_en);
        int waitc, low;
        tx_data  = b;
        tx_valid = 1'b1;
        waitc = 0;
        while (!tx_ready && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        if (!tx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_accept: tx_ready never rose, got 0 expected 1");
            tx_valid = 1'b0;
            return;
        end
        tx_exp_q.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
        low = 0;
        while (!tx_ready && low < 3000) begin
            if (toggle_en && low == 300) tx_enable = 1'b0;
            if (toggle_en && low == 900) tx_enable = 1'b1;
            low++;
            @(negedge clk);
        end
        $display("tx send 0x%02h: tx_ready low %0d cycles (expected %0d)", b, low, 10*DIV);
        check("tx_ready_low_cycles", low, 10*DIV);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = fr[i];
            repeat (DIV) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        rx_ev_t e;
        if (!stop_bit) begin
            if (!m_err) begin e.kind = EV_ERROR; e.data = m_data; rx_ev_q.push_back(e); end
            m_err = 1'b1;
        end else if (m_valid) begin
            if (!m_ovr) begin e.kind = EV_OVERRUN; e.data = m_data; rx_ev_q.push_back(e); end
            m_ovr = 1'b1;
        end else begin
            e.kind = EV_VALID; e.data = b; rx_ev_q.push_back(e);
            m_valid = 1'b1;
            m_data  = b;
        end
        $display("rx send 0x%02h stop=%b", b, stop_bit);
        send_rx(b, stop_bit);
    endtask

    task automatic handshake();
        rx_ev_t e;
        bit     was_valid;
        was_valid = m_valid;
        if (was_valid) begin
            e.kind = EV_CLEAR; e.data = m_data; rx_ev_q.push_back(e);
            m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        if (was_valid) check("rx_valid_after_handshake", rx_valid, 1'b0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tx_enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        rx_enable = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_error", rx_error, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);
        check("rst_hpos", hpos, 10'd0);
        check("rst_vpos", vpos, 10'd0);
        check("rst_hsync", hsync, 1'b1);
        check("rst_vsync", vsync, 1'b1);
        check("rst_display_on", display_on, 1'b1);
        reset = 1'b0;

        send_tx(8'hA5, 1'b0);

        rx_frame(8'h3C, 1'b1);
        repeat (300) @(negedge clk);
        check("rx_valid_held", rx_valid, m_valid);
        check("rx_data_held", rx_data, m_data);
        handshake();

        rx_frame(8'h55, 1'b0);
        rx_frame(8'h12, 1'b1);
        handshake();

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        handshake();

        // a short low pulse on the line must be rejected as a glitch
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        rx_in = 1'b1;
        repeat (400) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            rx_frame(8'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1) handshake();
            repeat ($urandom_range(1, 50)) @(negedge clk);
        end
        if ((m_err || m_ovr) && !m_valid) rx_frame(8'($urandom), 1'b1);
        if (m_valid) handshake();

        tx_enable = 1'b0;
        #1 check("tx_ready_disabled", tx_ready, 1'b0);
        tx_enable = 1'b1;
        #1 check("tx_ready_enabled", tx_ready, 1'b1);

        // reset in the middle of a frame
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (1000) @(negedge clk);
        check("tx_busy_before_reset", tx_ready, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx_out", tx_out, 1'b1);
        check("midrst_tx_ready", tx_ready, 1'b1);
        check("midrst_hpos", hpos, 10'd0);
        check("midrst_vpos", vpos, 10'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) send_tx(8'($urandom), (i != 0));

        repeat (50) @(negedge clk);
        check("tx_queue_drained", tx_exp_q.size(), 0);
        check("rx_queue_drained", rx_ev_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_vga_io.md
Name: uart_vga_io

Overview:
- Terminal/video I/O front end for the Game-of-Life top level.
- Contains an 8N1 UART transmitter, an 8N1 UART receiver with valid/ready handshake, and a 640x480 VGA timing generator.
- All three run on a single system clock; the VGA pixel clock equals clk.
- Board logic drives tx_* and consumes rx_*; hpos/vpos/display_on feed the pixel colour logic.

Parameters:
- CLOCK_RATE, 24000000, clk frequency in Hz.
- BAUD_RATE, 115200, UART bit rate; DIV = CLOCK_RATE/BAUD_RATE, truncated (208 by default).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_enable  in  1  transmitter enable.
- tx_valid  in  1  byte offered for transmit.
- tx_data  in  8  byte to send.
- tx_out  out  1  serial TX line; idle high.
- tx_ready  out  1  transmitter idle and able to accept a byte.
- rx_enable  in  1  receiver enable.
- rx_in  in  1  serial RX line, asynchronous.
- rx_ready  in  1  consumer accepts rx_data.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_error  out  1  framing error (stop bit read 0).
- rx_overrun  out  1  a byte arrived while rx_valid was still 1.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- display_on  out  1  visible-area flag.
- hpos  out  10  pixel column, 0..799.
- vpos  out  10  line, 0..524.

Behaviour:
- Reset (asynchronous, active-high): tx_out=1, tx_ready=1, rx_data=0, rx_valid=0, rx_error=0, rx_overrun=0, hpos=0, vpos=0, hsync=1, vsync=1. display_on=1, since it follows the counters.
- TX handshake:
  - tx_ready = idle & tx_enable.
  - A byte is accepted on a clk edge where tx_valid & tx_ready; tx_data is latched.
  - tx_ready goes 0 on the next cycle and stays 0 for 10*DIV cycles.
- TX framing:
  - Start bit 0, then data bits LSB first, then stop bit 1; each bit lasts exactly DIV cycles.
  - tx_ready returns to 1 on the cycle after the stop bit ends.
  - Deasserting tx_enable mid-frame does not abort the frame.
- RX input: rx_in passes through a 2-flop synchronizer before any use.
- RX start detection:
  - While idle and armed, a synchronized low starts a DIV/2 wait, after which the line is rechecked.
  - If the line is high at the recheck, treat it as a glitch and return to idle.
- RX sampling:
  - Sample 8 data bits at DIV intervals (mid-bit), LSB first.
  - Sample the stop bit DIV cycles after the last data bit.
- RX completion:
  - Stop bit = 1 and rx_valid = 0: rx_data <= byte, rx_valid <= 1.
  - Stop bit = 1 and rx_valid = 1 at the completion edge (no handshake that cycle): rx_overrun <= 1; the new byte is discarded and rx_data keeps the old byte.
  - Stop bit = 0: rx_error <= 1; rx_valid and rx_data are unchanged.
  - The receiver re-arms only after it sees the synchronized line high.
- RX handshake:
  - rx_valid & rx_ready at an edge: rx_valid, rx_error and rx_overrun all go 0 next cycle.
  - Handshake and completion on the same edge: the new byte is loaded, rx_valid stays 1, no overrun.
- rx_enable = 0: the receiver is forced idle, any partial frame is dropped, and flags are held.
- VGA counters:
  - hpos increments every clk and wraps 799->0; on that wrap vpos increments and wraps 524->0.
- VGA decode:
  - hsync = 0 for hpos 656..751, else 1.
  - vsync = 0 for vpos 490..491, else 1.
  - display_on = (hpos<640) & (vpos<480).
  - Outputs are registered or combinational from the counters, consistently for all three; the defining values are those above.
- Frame length = 800*525 = 420000 clk.

Decomposition:
- Shared package: DIV; the H constants (640 visible, 16 front porch, 96 sync, 48 back porch, 800 total); the V constants (480, 10, 2, 33, 525).
- Sub-module uart_bit_timer:
  - Down-counter loadable with DIV or DIV/2, emits a one-cycle tick on expiry.
  - Instantiated once in TX and once in RX.
- TX FSM states: IDLE, START, DATA, STOP.
- RX FSM states: IDLE, START_CHK, DATA, STOP, WAIT_HIGH.

Test Plan:
1. TX 0xA5 with tx_valid held until tx_ready falls -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit 208 cycles; tx_ready low for 2080 cycles, then 1.
2. RX 0x3C driven at 208 cycles/bit, rx_ready=0 -> rx_valid=1, rx_data=0x3C, held; raise rx_ready -> rx_valid=0 one cycle later.
3. RX 0x55 with stop bit 0 -> rx_error=1, rx_valid=0; line returns high and 0x12 is sent -> rx_valid=1, rx_data=0x12.
4. RX 0x11 then 0x22 with rx_ready=0 -> rx_overrun=1, rx_data=0x11; handshake clears rx_valid and rx_overrun.
5. VGA after reset -> hsync low exactly for hpos 656..751; display_on=0 at hpos=640; vpos increments on the hpos 799->0 wrap; vsync low for vpos 490..491; vpos 524->0 after 420000 cycles.
6. Assert reset mid-way through a TX frame -> tx_out=1 and tx_ready=1 immediately, hpos=vpos=0; after release a new byte transmits correctly.
